// File: rtl/aes_key_expansion.sv
// AES key schedule: NK-word cipher key -> (NR+1) round keys, w[0] in the MSBs.
// Combinational expansion; one output register with async active-low clear, so latency is 1 cycle.
module aes_key_expansion #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [32*NK-1:0]      i_cypher_key,
    output logic [128*(NR+1)-1:0] o_expanded_key
);
    localparam int NW = 4 * (NR + 1);

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = SBOX[2047 - 8*int'(x[8*b +: 8]) -: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input int j);
        case (j)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    if (!((NK == 4 && NR == 10) || (NK == 6 && NR == 12) || (NK == 8 && NR == 14))) begin : gen_bad_params
        $error("aes_key_expansion: illegal NK/NR pair");
    end

    logic [128*(NR+1)-1:0] schedule;

    // Each word lives in its own generate scope so the recurrence is a plain chain of nets.
    for (genvar i = 0; i < NW; i++) begin : gen_w
        logic [31:0] w;
        if (i < NK) begin : g_key
            assign w = i_cypher_key[32*NK-1-32*i -: 32];
        end else if (i % NK == 0) begin : g_rot
            assign w = gen_w[i-NK].w
                     ^ sub_word({gen_w[i-1].w[23:0], gen_w[i-1].w[31:24]})
                     ^ {rcon(i / NK), 24'h0};
        end else if (NK > 6 && i % NK == 4) begin : g_sub
            assign w = gen_w[i-NK].w ^ sub_word(gen_w[i-1].w);
        end else begin : g_xor
            assign w = gen_w[i-NK].w ^ gen_w[i-1].w;
        end
        assign schedule[128*(NR+1)-1-32*i -: 32] = w;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_expanded_key <= '0;
        end else begin
            o_expanded_key <= schedule;
        end
    end

endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: AES-128/192/256 instances against a GF(2^8)-derived reference schedule.
module tb_aes_key_expansion;
    logic          clk;
    logic          rst_n;
    logic [127:0]  key128;
    logic [191:0]  key192;
    logic [255:0]  key256;
    logic [1407:0] ek128;
    logic [1663:0] ek192;
    logic [1919:0] ek256;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  sb [256];
    logic [31:0] rw [60];

    aes_key_expansion #(.NK(4), .NR(10)) dut128 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cypher_key(key128), .o_expanded_key(ek128));
    aes_key_expansion #(.NK(6), .NR(12)) dut192 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cypher_key(key192), .o_expanded_key(ek192));
    aes_key_expansion #(.NK(8), .NR(14)) dut256 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cypher_key(key256), .o_expanded_key(ek256));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    // S-box from first principles: multiplicative inverse then the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    task automatic ref_expand(input int nk, input logic [255:0] key);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++) rw[i] = key[32*nk-1-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = rw[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            rw[i] = rw[i-nk] ^ t;
        end
    endtask

    function automatic logic [31:0] dut_word(input int nk, input int k);
        case (nk)
            4:       return ek128[1407-32*k -: 32];
            6:       return ek192[1663-32*k -: 32];
            default: return ek256[1919-32*k -: 32];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_sched(input string tag, input int nk, input logic [255:0] key);
        ref_expand(nk, key);
        for (int k = 0; k < 4*(nk+7); k++)
            check($sformatf("%s_nk%0d_w%0d", tag, nk, k), dut_word(nk, k), rw[k]);
    endtask

    task automatic check_keys(input string tag, input logic [127:0] k4,
                              input logic [191:0] k6, input logic [255:0] k8);
        check_sched(tag, 4, 256'(k4));
        check_sched(tag, 6, 256'(k6));
        check_sched(tag, 8, k8);
    endtask

    task automatic check_zero(input string tag);
        for (int n = 4; n <= 8; n += 2)
            for (int k = 0; k < 4*(n+7); k++)
                check($sformatf("%s_nk%0d_w%0d", tag, n, k), dut_word(n, k), 32'h0);
    endtask

    initial begin
        logic [127:0] p128;
        logic [191:0] p192;
        logic [255:0] p256;

        build_sbox();
        rst_n  = 1'b0;
        key128 = '0;
        key192 = '0;
        key256 = '0;

        @(negedge clk);
        check_zero("reset");

        // FIPS-197 appendix keys
        key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        check("a128_w0", dut_word(4, 0), 32'h2b7e1516);
        check("a128_w3", dut_word(4, 3), 32'h09cf4f3c);
        check("a128_w4", dut_word(4, 4), 32'ha0fafe17);
        check("a128_w40", dut_word(4, 40), 32'hd014f9a8);
        check("a128_w41", dut_word(4, 41), 32'hc9ee2589);
        check("a128_w42", dut_word(4, 42), 32'he13f0cc8);
        check("a128_w43", dut_word(4, 43), 32'hb6630ca6);
        check("a192_w6", dut_word(6, 6), 32'hfe0c91f7);
        check("a192_w48", dut_word(6, 48), 32'he98ba06f);
        check("a192_w49", dut_word(6, 49), 32'h448c773c);
        check("a192_w50", dut_word(6, 50), 32'h8ecc7204);
        check("a192_w51", dut_word(6, 51), 32'h01002202);
        check("a256_w8", dut_word(8, 8), 32'h9ba35411);
        check("a256_w12", dut_word(8, 12), 32'ha8b09c1a);
        check("a256_w56", dut_word(8, 56), 32'hfe4890d1);
        check("a256_w57", dut_word(8, 57), 32'he6188d0b);
        check("a256_w58", dut_word(8, 58), 32'h046df344);
        check("a256_w59", dut_word(8, 59), 32'h706c631e);
        check_keys("fips", key128, key192, key256);

        // Random keys changed mid-cycle: output holds old schedule until the next rise.
        for (int it = 0; it < 12; it++) begin
            @(negedge clk);
            p128 = key128;
            p192 = key192;
            p256 = key256;
            key128 = (it == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
            key192 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            key256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            check_keys($sformatf("hold%0d", it), p128, p192, p256);
            @(posedge clk); #1;
            check_keys($sformatf("rand%0d", it), key128, key192, key256);
            if (it == 0) begin
                check("zero_w4", dut_word(4, 4), 32'h62636363);
                check("zero_w43", dut_word(4, 43), 32'h6f8f188e);
            end
        end

        // Asynchronous clear mid-cycle, hold through an edge, release between edges.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("arst_async");
        @(posedge clk); #1;
        check_zero("arst_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("arst_released");
        @(posedge clk); #1;
        check_keys("reload", key128, key192, key256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
